// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-port bundle for the shared ALU arbiter.
// The slave modport is the arbiter side; master is the issue logic, consumers and ALU.
interface alu_share_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             p0_valid, p1_valid;
  logic             p0_ready, p1_ready;
  logic [31:0]      p0_op1, p0_op2, p1_op1, p1_op2;
  logic [3:0]       p0_ctrl, p1_ctrl;
  logic [TAG_W-1:0] p0_tag, p1_tag;

  logic [31:0]      alu_op1, alu_op2;
  logic [3:0]       alu_ctrl;
  logic [31:0]      alu_result;
  logic             alu_zero, alu_sign, alu_branch_u;

  logic             r0_valid, r1_valid;
  logic             r0_ready, r1_ready;
  logic [31:0]      r0_result, r1_result;
  logic [2:0]       r0_flags, r1_flags;
  logic [TAG_W-1:0] r0_tag, r1_tag;

  modport slave (
    input  p0_valid, p1_valid, p0_op1, p0_op2, p1_op1, p1_op2,
    input  p0_ctrl, p1_ctrl, p0_tag, p1_tag,
    output p0_ready, p1_ready,
    output alu_op1, alu_op2, alu_ctrl,
    input  alu_result, alu_zero, alu_sign, alu_branch_u,
    output r0_valid, r1_valid, r0_result, r1_result,
    output r0_flags, r1_flags, r0_tag, r1_tag,
    input  r0_ready, r1_ready
  );

  modport master (
    output p0_valid, p1_valid, p0_op1, p0_op2, p1_op1, p1_op2,
    output p0_ctrl, p1_ctrl, p0_tag, p1_tag,
    input  p0_ready, p1_ready,
    input  alu_op1, alu_op2, alu_ctrl,
    output alu_result, alu_zero, alu_sign, alu_branch_u,
    input  r0_valid, r1_valid, r0_result, r1_result,
    input  r0_flags, r1_flags, r0_tag, r1_tag,
    output r0_ready, r1_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of the single combinational RV32I ALU: steers one
// granted request per cycle onto the ALU and returns its result one cycle later.
module alu_share_arbiter #(
  parameter int TAG_W      = 4,
  parameter int FIXED_PRIO = 0,
  parameter int STARVE_MAX = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_share_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]       req_vld_p0;
  logic [1:0]       rsp_rdy_p0;
  logic [1:0]       elig_p0;
  logic [1:0]       gnt_p0;
  logic             tie_p1_p0;
  logic [TAG_W-1:0] req_tag_p0 [2];
  logic [2:0]       alu_flags_p0;

  logic             last_p1;
  logic [3:0]       starve_cnt;

  logic [1:0]       rsp_vld_p1;
  logic [31:0]      rsp_res_p1 [2];
  logic [2:0]       rsp_flg_p1 [2];
  logic [TAG_W-1:0] rsp_tag_p1 [2];

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  function automatic logic [2:0] pack_flags(input logic bu, input logic sgn, input logic zro);
    return {bu, sgn, zro};
  endfunction

  // ---- stage 0: eligibility, grant and ALU steering (combinational) ----
  assign req_vld_p0    = {bus.p1_valid, bus.p0_valid};
  assign rsp_rdy_p0    = {bus.r1_ready, bus.r0_ready};
  assign req_tag_p0[0] = bus.p0_tag;
  assign req_tag_p0[1] = bus.p1_tag;
  assign alu_flags_p0  = pack_flags(bus.alu_branch_u, bus.alu_sign, bus.alu_zero);

  always_comb begin
    // A slot being drained this cycle counts as free, so it can be refilled at once.
    elig_p0 = req_vld_p0 & (~rsp_vld_p1 | rsp_rdy_p0);
    if (FIXED_PRIO != 0) tie_p1_p0 = (starve_cnt == STARVE_LIM);
    else                 tie_p1_p0 = ~last_p1;
    gnt_p0[0] = elig_p0[0] & ~(elig_p0[1] &  tie_p1_p0);
    gnt_p0[1] = elig_p0[1] & ~(elig_p0[0] & ~tie_p1_p0);
  end

  assign bus.p0_ready = gnt_p0[0];
  assign bus.p1_ready = gnt_p0[1];

  always_comb begin
    bus.alu_op1  = '0;
    bus.alu_op2  = '0;
    bus.alu_ctrl = '0;
    if (gnt_p0[0]) begin
      bus.alu_op1  = bus.p0_op1;
      bus.alu_op2  = bus.p0_op2;
      bus.alu_ctrl = bus.p0_ctrl;
    end else if (gnt_p0[1]) begin
      bus.alu_op1  = bus.p1_op1;
      bus.alu_op2  = bus.p1_op2;
      bus.alu_ctrl = bus.p1_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_p1 <= 1'b1;
    else if (|gnt_p0)       last_p1 <= gnt_p0[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           starve_cnt <= '0;
    else if ((FIXED_PRIO == 0) || !elig_p0[1] || gnt_p0[1]) starve_cnt <= '0;
    else                                                  starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
  end

  // ---- stage 1: per-requester response registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= '0;
      for (int i = 0; i < 2; i++) begin
        rsp_res_p1[i] <= '0;
        rsp_flg_p1[i] <= '0;
        rsp_tag_p1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt_p0[i]) begin
          rsp_vld_p1[i] <= 1'b1;
          rsp_res_p1[i] <= bus.alu_result;
          rsp_flg_p1[i] <= alu_flags_p0;
          rsp_tag_p1[i] <= req_tag_p0[i];
        end else if (rsp_rdy_p0[i]) begin
          rsp_vld_p1[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.r0_valid  = rsp_vld_p1[0];
  assign bus.r1_valid  = rsp_vld_p1[1];
  assign bus.r0_result = rsp_res_p1[0];
  assign bus.r1_result = rsp_res_p1[1];
  assign bus.r0_flags  = rsp_flg_p1[0];
  assign bus.r1_flags  = rsp_flg_p1[1];
  assign bus.r0_tag    = rsp_tag_p1[0];
  assign bus.r1_tag    = rsp_tag_p1[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a round-robin instance driven by directed
// vectors and a fixed-priority instance checked for its starvation pattern.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_fx = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.TAG_W(4)) m ();
  alu_share_arbiter_if #(.TAG_W(4)) fx ();

  alu_share_arbiter #(.TAG_W(4), .FIXED_PRIO(0), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(m.slave));
  alu_share_arbiter #(.TAG_W(4), .FIXED_PRIO(1), .STARVE_MAX(3)) dut_fx (
    .clk(clk), .rst_n(rst_fx), .bus(fx.slave));

  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a << b[4:0];
      4'b0100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0110: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = a ^ b;
      4'b1010: r = a >> b[4:0];
      4'b1011: r = 32'($signed(a) >>> b[4:0]);
      4'b1100: r = a | b;
      4'b1110: r = a & b;
      default: r = 32'd0;
    endcase
    return {a < b, r[31], r == 32'd0, r};
  endfunction

  assign {m.alu_branch_u, m.alu_sign, m.alu_zero, m.alu_result} =
         alu_model(m.alu_op1, m.alu_op2, m.alu_ctrl);
  assign {fx.alu_branch_u, fx.alu_sign, fx.alu_zero, fx.alu_result} =
         alu_model(fx.alu_op1, fx.alu_op2, fx.alu_ctrl);

  int n_cmp = 0;
  int n_bad = 0;
  bit push_en = 1'b1;
  logic [38:0] q0[$];
  logic [38:0] q1[$];
  logic [4:0]  fq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitors: pop the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    logic [38:0] e;
    logic [4:0]  f;
    if (m.r0_valid && m.r0_ready) begin
      if (q0.size() == 0) chk("r0_unexpected", 64'(m.r0_tag), 64'hDEAD);
      else begin e = q0.pop_front(); chk("r0_resp", 64'({m.r0_result, m.r0_flags, m.r0_tag}), 64'(e)); end
    end
    if (m.r1_valid && m.r1_ready) begin
      if (q1.size() == 0) chk("r1_unexpected", 64'(m.r1_tag), 64'hDEAD);
      else begin e = q1.pop_front(); chk("r1_resp", 64'({m.r1_result, m.r1_flags, m.r1_tag}), 64'(e)); end
    end
    if (fx.r0_valid && fx.r0_ready) begin
      if (fq.size() == 0) chk("fx_r0_unexpected", 64'(fx.r0_tag), 64'hDEAD);
      else begin f = fq.pop_front(); chk("fx_resp", 64'({1'b0, fx.r0_tag}), 64'(f)); end
    end
    if (fx.r1_valid && fx.r1_ready) begin
      if (fq.size() == 0) chk("fx_r1_unexpected", 64'(fx.r1_tag), 64'hDEAD);
      else begin f = fq.pop_front(); chk("fx_resp", 64'({1'b1, fx.r1_tag}), 64'(f)); end
    end
  end

  task automatic rq0(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c, input logic [3:0] t);
    m.p0_valid = v; m.p0_op1 = a; m.p0_op2 = b; m.p0_ctrl = c; m.p0_tag = t;
  endtask

  task automatic rq1(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c, input logic [3:0] t);
    m.p1_valid = v; m.p1_op1 = a; m.p1_op2 = b; m.p1_ctrl = c; m.p1_tag = t;
  endtask

  // One cycle: check grants and steering mid-cycle, queue the expected responses.
  task automatic step(input logic g0, input logic g1,
                      input logic [31:0] e0r, input logic [2:0] e0f,
                      input logic [31:0] e1r, input logic [2:0] e1f);
    logic [31:0] eop1;
    @(negedge clk);
    chk("p0_ready", 64'(m.p0_ready), 64'(g0));
    chk("p1_ready", 64'(m.p1_ready), 64'(g1));
    eop1 = g0 ? m.p0_op1 : (g1 ? m.p1_op1 : 32'd0);
    chk("alu_op1", 64'(m.alu_op1), 64'(eop1));
    if (g0 && push_en) q0.push_back({e0r, e0f, m.p0_tag});
    if (g1 && push_en) q1.push_back({e1r, e1f, m.p1_tag});
    @(posedge clk); #1;
  endtask

  initial begin
    rq0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    rq1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    m.r0_ready = 1'b1; m.r1_ready = 1'b1;
    fx.p0_valid = 1'b0; fx.p1_valid = 1'b0;
    fx.p0_op1 = '0; fx.p0_op2 = '0; fx.p0_ctrl = '0; fx.p0_tag = '0;
    fx.p1_op1 = '0; fx.p1_op2 = '0; fx.p1_ctrl = '0; fx.p1_tag = '0;
    fx.r0_ready = 1'b1; fx.r1_ready = 1'b1;

    #12;
    chk("rst_r0_valid", 64'(m.r0_valid), 64'd0);
    chk("rst_r1_valid", 64'(m.r1_valid), 64'd0);
    chk("rst_r0_result", 64'(m.r0_result), 64'd0);
    chk("rst_alu_ctrl", 64'(m.alu_ctrl), 64'd0);
    rst_n = 1'b1;
    rst_fx = 1'b1;
    @(posedge clk); #1;

    // P0 alone, then both contending under round-robin
    rq0(1'b1, 32'd5, 32'd3, 4'b0000, 4'd2);
    step(1'b1, 1'b0, 32'd8, 3'b000, 32'd0, 3'b000);
    rq0(1'b1, 32'd10, 32'd20, 4'b0000, 4'd3);
    rq1(1'b1, 32'd100, 32'd1, 4'b0001, 4'd5);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd99, 3'b000);
    rq1(1'b1, 32'd7, 32'd7, 4'b0001, 4'd6);
    step(1'b1, 1'b0, 32'd30, 3'b100, 32'd0, 3'b000);
    rq0(1'b1, 32'h0F, 32'h3C, 4'b1110, 4'd4);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd0, 3'b001);
    rq1(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0110, 4'd7);
    step(1'b1, 1'b0, 32'h0C, 3'b100, 32'd0, 3'b000);
    rq0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd0, 3'b001);

    // Backpressure on r0
    rq1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    rq0(1'b1, 32'h8000_0000, 32'd0, 4'b0000, 4'd8);
    m.r0_ready = 1'b0;
    step(1'b1, 1'b0, 32'h8000_0000, 3'b010, 32'd0, 3'b000);
    rq0(1'b1, 32'd1, 32'd1, 4'b0000, 4'd9);
    rq1(1'b1, 32'd3, 32'd2, 4'b0010, 4'd10);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd12, 3'b000);
    rq1(1'b1, 32'd9, 32'd9, 4'b1000, 4'd11);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd0, 3'b001);
    chk("r0_hold_result", 64'(m.r0_result), 64'h8000_0000);
    chk("r0_hold_tag", 64'(m.r0_tag), 64'd8);
    m.r0_ready = 1'b1;
    rq1(1'b1, 32'hFFFF_FFF0, 32'd2, 4'b1011, 4'd12);
    step(1'b1, 1'b0, 32'd2, 3'b000, 32'd0, 3'b000);
    rq0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'hFFFF_FFFC, 3'b010);
    rq1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 32'd0, 3'b000, 32'd0, 3'b000);

    // Asynchronous reset while r1 holds an unconsumed response
    push_en = 1'b0;
    m.r1_ready = 1'b0;
    rq1(1'b1, 32'd4, 32'd4, 4'b0000, 4'd13);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd8, 3'b000);
    rq1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 32'd0, 3'b000, 32'd0, 3'b000);
    chk("r1_pending_valid", 64'(m.r1_valid), 64'd1);
    chk("r1_pending_result", 64'(m.r1_result), 64'd8);
    chk("r1_pending_tag", 64'(m.r1_tag), 64'd13);
    #2 rst_n = 1'b0;
    #1;
    chk("async_r1_valid", 64'(m.r1_valid), 64'd0);
    chk("async_r1_result", 64'(m.r1_result), 64'd0);
    chk("async_r1_tag", 64'(m.r1_tag), 64'd0);
    chk("async_r1_flags", 64'(m.r1_flags), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    push_en = 1'b1;
    m.r1_ready = 1'b1;
    rq0(1'b1, 32'd6, 32'd7, 4'b0100, 4'd1);
    rq1(1'b1, 32'd2, 32'd3, 4'b1100, 4'd2);
    step(1'b1, 1'b0, 32'd1, 3'b100, 32'd0, 3'b000);
    rq0(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 32'd0, 3'b000, 32'd3, 3'b100);
    rq1(1'b0, 32'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 32'd0, 3'b000, 32'd0, 3'b000);
    step(1'b0, 1'b0, 32'd0, 3'b000, 32'd0, 3'b000);

    // Fixed priority with anti-starvation: P0,P0,P0,P1 repeating
    for (int k = 0; k < 12; k++) begin
      fx.p0_valid = 1'b1; fx.p0_op1 = 32'(k); fx.p0_op2 = 32'd1; fx.p0_tag = 4'(k);
      fx.p1_valid = 1'b1; fx.p1_op1 = 32'(k); fx.p1_op2 = 32'd2; fx.p1_tag = 4'(k + 8);
      @(negedge clk);
      chk("fx_p1_ready", 64'(fx.p1_ready), 64'((k % 4) == 3));
      if ((k % 4) == 3) fq.push_back({1'b1, 4'(k + 8)});
      else              fq.push_back({1'b0, 4'(k)});
      @(posedge clk); #1;
    end
    fx.p0_valid = 1'b0; fx.p1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("fq_drained", 64'(fq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
